// File: rtl/pipe_pkg.sv
// Shared encodings for the IF/ID/EX/WB pipeline sequencer and its hazard unit.
package pipe_pkg;

  // Sequencer FSM states; the numeric values are visible on seq_state.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_HALTED = 3'd2,
    ST_FLUSH  = 3'd3
  } seq_state_e;

  // Operand source selects presented to the EX-stage operand muxes.
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_EX      = 2'd1,
    FWD_WB      = 2'd2
  } fwd_sel_e;

  // Opcode the pipeline latches load when flushed or bubbled.
  localparam logic [3:0] NOP_OPCODE = 4'h0;

  // Per-source outcome of the hazard compare.
  typedef struct packed {
    logic     stall;
    fwd_sel_e sel;
  } src_res_t;

endpackage

// File: rtl/pipeline_sequencer_hazard_unit.sv
// RAW hazard detection between the ID instruction and the EX/WB instructions.
// Build option: PIPE_FWD_EN enables EX/WB bypass selects instead of stalling.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              ex_wr,
  input  logic              wb_wr,
  input  logic              ex_is_load,
  output logic              stall,
  output fwd_sel_e          fwd_sel_rs1,
  output fwd_sel_e          fwd_sel_rs2
);

  // Register 0 is an ordinary register here, so every address compares exactly.
  logic ex_m1, ex_m2, wb_m1, wb_m2;
  assign ex_m1 = id_use_rs1 & ex_wr & (id_rs1 == ex_rd);
  assign ex_m2 = id_use_rs2 & ex_wr & (id_rs2 == ex_rd);
  assign wb_m1 = id_use_rs1 & wb_wr & (id_rs1 == wb_rd);
  assign wb_m2 = id_use_rs2 & wb_wr & (id_rs2 == wb_rd);

`ifdef PIPE_FWD_EN
  // EX is the younger producer, so its result wins over WB; a load in EX has no data yet.
  function automatic src_res_t resolve(input logic ex_m, input logic wb_m, input logic load);
    src_res_t r;
    r.stall = 1'b0;
    r.sel   = FWD_REGFILE;
    if (ex_m) begin
      if (load) r.stall = 1'b1;
      else      r.sel   = FWD_EX;
    end else if (wb_m) begin
      r.sel = FWD_WB;
    end
    return r;
  endfunction

  src_res_t res1, res2;
  assign res1        = resolve(ex_m1, wb_m1, ex_is_load);
  assign res2        = resolve(ex_m2, wb_m2, ex_is_load);
  assign stall       = res1.stall | res2.stall;
  assign fwd_sel_rs1 = res1.sel;
  assign fwd_sel_rs2 = res2.sel;
`else
  // Without bypass the regfile is the only source and is not write-through,
  // so any match in EX or WB must wait.
  logic unused_load;
  assign unused_load = ex_is_load;
  assign stall       = ex_m1 | ex_m2 | wb_m1 | wb_m2;
  assign fwd_sel_rs1 = FWD_REGFILE;
  assign fwd_sel_rs2 = FWD_REGFILE;
`endif

endmodule

// File: rtl/pipeline_sequencer.sv
// Central run/halt/flush sequencer for the 4-stage IF/ID/EX/WB pipeline.
// Stage controls are combinational from the registered state and current inputs.
// Build option: PIPE_FWD_EN (see hazard_unit) turns most RAW stalls into bypasses.
module pipeline_sequencer
  import pipe_pkg::*;
#(
  parameter int PC_W        = 6,
  parameter int REG_AW      = 3,
  parameter int RESTART_CYC = 3,
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   controller_enable,
  input  logic                   resume,
  input  logic                   restart,
  input  logic                   wb_halt,
  input  logic [REG_AW-1:0]      id_rs1,
  input  logic [REG_AW-1:0]      id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [REG_AW-1:0]      ex_rd,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic                   ex_wr,
  input  logic                   wb_wr,
  input  logic                   ex_is_load,
  input  logic                   ex_jump_taken,
  input  logic [PC_W-1:0]        ex_jump_target,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   ex_wb_en,
  output logic                   wb_en,
  output logic                   pc_load,
  output logic [PC_W-1:0]        pc_load_val,
  output logic [1:0]             fwd_sel_rs1,
  output logic [1:0]             fwd_sel_rs2,
  output logic [2:0]             seq_state,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int FC_W = $clog2(RESTART_CYC + 1);

  seq_state_e             state_q, state_d;
  logic [FC_W-1:0]        flush_cnt_q, flush_load_val;
  logic                   flush_load;
  logic                   count_stall;
  logic [STALL_CNT_W-1:0] stall_count_q;
  logic                   hz_stall;
  fwd_sel_e               hz_sel1, hz_sel2;

  hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .wb_rd       (wb_rd),
    .ex_wr       (ex_wr),
    .wb_wr       (wb_wr),
    .ex_is_load  (ex_is_load),
    .stall       (hz_stall),
    .fwd_sel_rs1 (hz_sel1),
    .fwd_sel_rs2 (hz_sel2)
  );

  // Next-state and stage controls; priority in RUN is halt > jump > stall.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d        = state_q;
    flush_load     = 1'b0;
    flush_load_val = '0;
    count_stall    = 1'b0;
    pc_en          = 1'b0;
    if_id_en       = 1'b0;
    if_id_flush    = 1'b1;
    id_ex_bubble   = 1'b1;
    ex_wb_en       = 1'b0;
    wb_en          = 1'b0;
    pc_load        = 1'b0;
    pc_load_val    = '0;
    fwd_sel_rs1    = FWD_REGFILE;
    fwd_sel_rs2    = FWD_REGFILE;
    unique case (state_q)
      ST_IDLE: begin
        if (controller_enable) begin
          state_d        = ST_FLUSH;
          flush_load     = 1'b1;
          flush_load_val = FC_W'(1);
        end
      end
      ST_RUN: begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_wb_en     = 1'b1;
        wb_en        = 1'b1;
        fwd_sel_rs1  = hz_sel1;
        fwd_sel_rs2  = hz_sel2;
        if (wb_halt) begin
          // The HALT in WB retires; everything younger is squashed.
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          ex_wb_en     = 1'b0;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = ST_HALTED;
        end else if (ex_jump_taken) begin
          // The stalled ID instruction is on the wrong path, so no stall is counted.
          pc_load      = 1'b1;
          pc_load_val  = ex_jump_target;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (hz_stall) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          count_stall  = 1'b1;
        end
      end
      ST_HALTED: begin
        if (resume) state_d = ST_RUN;
      end
      ST_FLUSH: begin
        pc_load  = 1'b1;
        ex_wb_en = 1'b1;
        if (flush_cnt_q <= FC_W'(1)) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (restart) begin
      state_d        = ST_FLUSH;
      flush_load     = 1'b1;
      flush_load_val = FC_W'(RESTART_CYC);
    end
  end

  // State, flush-length counter and saturating stall counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q       <= ST_IDLE;
      flush_cnt_q   <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush_load)
        flush_cnt_q <= flush_load_val;
      else if (state_q == ST_FLUSH && flush_cnt_q != '0)
        flush_cnt_q <= flush_cnt_q - FC_W'(1);
      if (count_stall && stall_count_q != {STALL_CNT_W{1'b1}})
        stall_count_q <= stall_count_q + STALL_CNT_W'(1);
    end
  end

  assign seq_state   = state_q;
  assign stall_count = stall_count_q;

endmodule
